// File: rtl/i2c_byte_fifo.sv
// i2c_byte_fifo: synchronous first-word-fall-through FIFO used for the TX and
// RX byte paths between the APB bridge and the I2C core.
// The head word is always presented on RD_DATA while EMPTY=0. Overflow and
// underflow errors are sticky until CLR_ERR or PRESET.
// Optional feature macro: FIFO_WATERMARK_EN enables the registered
// ALMOST_FULL / ALMOST_EMPTY compares. When it is undefined, both ports are
// tied to 0.
module i2c_byte_fifo #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned AWIDTH   = 3,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              WR_EN,
  input  logic [DWIDTH-1:0] WR_DATA,
  input  logic              RD_EN,
  output logic [DWIDTH-1:0] RD_DATA,
  output logic              FULL,
  output logic              EMPTY,
  output logic [AWIDTH:0]   LEVEL,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
  input  logic              CLR_ERR,
  output logic              ALMOST_FULL,
  output logic              ALMOST_EMPTY
);

  localparam int unsigned     DEPTH   = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_L = DEPTH[AWIDTH:0];

  // Push/pop semantics. A push is accepted when WR_EN=1 and the FIFO is not
  // full, or when it is full and a pop is accepted on the same edge. A pop is
  // accepted when RD_EN=1 and EMPTY=0. Each accepted push writes one word, and
  // each accepted pop retires the head word at the clock edge. There is no
  // back-pressure handshake. A refused request only raises the matching
  // sticky error flag.
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              full_w, empty_w;
  logic              push_v, pop_v;

  // Decode occupancy flags, accept/reject requests, and compute the next state.
  always_comb begin
    full_w   = (level_q == DEPTH_L);
    empty_w  = (level_q == '0);
    pop_v    = RD_EN & ~empty_w;
    push_v   = WR_EN & (~full_w | pop_v);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (push_v) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
    if (pop_v)  rd_ptr_d = rd_ptr_q + AWIDTH'(1);
    unique case ({push_v, pop_v})
      2'b10:   level_d = level_q + (AWIDTH+1)'(1);
      2'b01:   level_d = level_q - (AWIDTH+1)'(1);
      default: level_d = level_q;
    endcase
    // A new error wins over a clear that arrives in the same cycle.
    if (WR_EN & ~push_v)     ovf_d = 1'b1;
    else if (CLR_ERR)        ovf_d = 1'b0;
    if (RD_EN & ~pop_v)      udf_d = 1'b1;
    else if (CLR_ERR)        udf_d = 1'b0;
  end

  // Register the pointers, the occupancy counter and the sticky error flags.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Write storage. It is not reset, because reset only empties the FIFO.
  always_ff @(posedge PCLK) begin
    if (!PRESET && push_v) mem_q[wr_ptr_q] <= WR_DATA;
  end

  assign RD_DATA   = empty_w ? '0 : mem_q[rd_ptr_q];
  assign FULL      = full_w;
  assign EMPTY     = empty_w;
  assign LEVEL     = level_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;

`ifdef FIFO_WATERMARK_EN
  localparam logic [AWIDTH:0] AF_L = AF_LEVEL[AWIDTH:0];
  localparam logic [AWIDTH:0] AE_L = AE_LEVEL[AWIDTH:0];
  logic af_q, ae_q;

  // Compare the watermarks against the next level, so they change on the same edge as LEVEL.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (level_d >= AF_L);
      ae_q <= (level_d <= AE_L);
    end
  end

  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
`else
  logic unused_wm;
  assign unused_wm    = ^{AF_LEVEL, AE_LEVEL};
  assign ALMOST_FULL  = 1'b0;
  assign ALMOST_EMPTY = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_byte_fifo.sv
// tb_i2c_byte_fifo: self-checking bench for i2c_byte_fifo.
// It runs a directed vector table, then hand-written wrap and reset sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_i2c_byte_fifo;

  // ---------------- clock / reset / DUT ----------------
  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        WR_EN;
  logic [31:0] WR_DATA;
  logic        RD_EN;
  logic [31:0] RD_DATA;
  logic        FULL, EMPTY;
  logic [3:0]  LEVEL;
  logic        OVERFLOW, UNDERFLOW;
  logic        CLR_ERR;
  logic        ALMOST_FULL, ALMOST_EMPTY;

  always #5 PCLK = ~PCLK;

  i2c_byte_fifo dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .WR_EN        (WR_EN),
    .WR_DATA      (WR_DATA),
    .RD_EN        (RD_EN),
    .RD_DATA      (RD_DATA),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .LEVEL        (LEVEL),
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW),
    .CLR_ERR      (CLR_ERR),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] d, input logic r, input logic c);
    WR_EN   = w;
    WR_DATA = d;
    RD_EN   = r;
    CLR_ERR = c;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
  endtask

  function automatic logic exp_af(input int n);
`ifdef FIFO_WATERMARK_EN
    return n >= 6;
`else
    return (n < 0);
`endif
  endfunction

  function automatic logic exp_ae(input int n);
`ifdef FIFO_WATERMARK_EN
    return n <= 1;
`else
    return (n < 0);
`endif
  endfunction

  // ---------------- reference model ----------------
  // The contents are an ordered queue of words. The occupancy is the queue size.
  logic [31:0] m_q[$];
  logic        m_ovf, m_udf;

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic [31:0] d, input logic r, input logic c);
    bit full, empty, pop_ok, push_ok;
    full    = (m_q.size() == 8);
    empty   = (m_q.size() == 0);
    pop_ok  = r && !empty;
    push_ok = w && (!full || pop_ok);
    if (w && !push_ok)      m_ovf = 1'b1;
    else if (c)             m_ovf = 1'b0;
    if (r && !pop_ok)       m_udf = 1'b1;
    else if (c)             m_udf = 1'b0;
    if (pop_ok)  void'(m_q.pop_front());
    if (push_ok) m_q.push_back(d);
  endtask

  task automatic check_model(input string tag);
    int n;
    logic [31:0] head;
    n    = m_q.size();
    head = (n == 0) ? 32'h0 : m_q[0];
    chk({tag, " LEVEL"},        32'(LEVEL),        32'(n));
    chk({tag, " RD_DATA"},      RD_DATA,           head);
    chk({tag, " FULL"},         32'(FULL),         32'(n == 8));
    chk({tag, " EMPTY"},        32'(EMPTY),        32'(n == 0));
    chk({tag, " OVERFLOW"},     32'(OVERFLOW),     32'(m_ovf));
    chk({tag, " UNDERFLOW"},    32'(UNDERFLOW),    32'(m_udf));
    chk({tag, " ALMOST_FULL"},  32'(ALMOST_FULL),  32'(exp_af(n)));
    chk({tag, " ALMOST_EMPTY"}, 32'(ALMOST_EMPTY), 32'(exp_ae(n)));
  endtask

  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic c,
                      input string tag);
    drive(w, d, r, c);
    tick();
    model_step(w, d, r, c);
    check_model(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd;
    logic        clr;
    logic [3:0]  lvl;
    logic [31:0] dout;
    logic        ovf;
    logic        udf;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  initial begin
    PRESET = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill the FIFO with A5A5_0001..0008. The head stays at the first word.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 32'hA5A5_0001 + i, 1'b0, 1'b0, 4'(i + 1), 32'hA5A5_0001, 1'b0, 1'b0};
    // A push while full with no pop is dropped and sets OVERFLOW.
    vecs[8]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'd8, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 4'd8, 32'hA5A5_0001, 1'b0, 1'b0};
    // A push and a pop on the same edge while full both succeed.
    vecs[10] = '{1'b1, 32'h0000_0099, 1'b1, 1'b0, 4'd8, 32'hA5A5_0002, 1'b0, 1'b0};
    for (int j = 0; j < 6; j++)
      vecs[11 + j] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'(7 - j), 32'hA5A5_0003 + j, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 32'h0,         1'b1, 1'b0, 4'd1, 32'h0000_0099, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 32'h0,         1'b1, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0};
    // A pop while empty sets UNDERFLOW, a clear resets it, and a clear plus a new error leaves it set.
    vecs[19] = '{1'b0, 32'h0,         1'b1, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1};
    vecs[20] = '{1'b0, 32'h0,         1'b0, 1'b1, 4'd0, 32'h0,         1'b0, 1'b0};
    vecs[21] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'd0, 32'h0,         1'b0, 1'b1};
    // A push and a pop while empty: the push lands and the pop is refused.
    vecs[22] = '{1'b1, 32'h0000_1234, 1'b1, 1'b0, 4'd1, 32'h0000_1234, 1'b0, 1'b1};
    vecs[23] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'd0, 32'h0,         1'b0, 1'b0};

    // Check the reset state.
    do_reset();
    chk("rst LEVEL",        32'(LEVEL),        32'd0);
    chk("rst EMPTY",        32'(EMPTY),        32'd1);
    chk("rst FULL",         32'(FULL),         32'd0);
    chk("rst OVERFLOW",     32'(OVERFLOW),     32'd0);
    chk("rst UNDERFLOW",    32'(UNDERFLOW),    32'd0);
    chk("rst RD_DATA",      RD_DATA,           32'd0);
    chk("rst ALMOST_FULL",  32'(ALMOST_FULL),  32'(exp_af(0)));
    chk("rst ALMOST_EMPTY", 32'(ALMOST_EMPTY), 32'(exp_ae(0)));

    // Apply the directed table.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr);
      tick();
      chk($sformatf("v%0d LEVEL", i),     32'(LEVEL),     32'(vecs[i].lvl));
      chk($sformatf("v%0d RD_DATA", i),   RD_DATA,        vecs[i].dout);
      chk($sformatf("v%0d FULL", i),      32'(FULL),      32'(vecs[i].lvl == 4'd8));
      chk($sformatf("v%0d EMPTY", i),     32'(EMPTY),     32'(vecs[i].lvl == 4'd0));
      chk($sformatf("v%0d OVERFLOW", i),  32'(OVERFLOW),  32'(vecs[i].ovf));
      chk($sformatf("v%0d UNDERFLOW", i), 32'(UNDERFLOW), 32'(vecs[i].udf));
    end

    // Pointer wrap: alternate a push and a pop of 0..19, starting from nonzero pointers.
    model_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b0, $sformatf("wrap%0d push", i));
      step(1'b0, 32'h0,  1'b1, 1'b0, $sformatf("wrap%0d pop", i));
    end

    // Full overflow sequence with an ordered drain that never returns DEADBEEF.
    for (int i = 0; i < 8; i++) step(1'b1, 32'hA5A5_0001 + i, 1'b0, 1'b0, "ovf fill");
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, "ovf push");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d head", i), RD_DATA, 32'hA5A5_0001 + i);
      step(1'b0, 32'h0, 1'b1, 1'b0, "ovf drain");
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, "ovf clear");

    // Reset mid-operation discards the stored words and clears the error flags.
    step(1'b0, 32'h0, 1'b1, 1'b0, "pre-rst udf");
    for (int i = 0; i < 5; i++) step(1'b1, 32'h5000 + i, 1'b0, 1'b0, "pre-rst push");
    do_reset();
    model_reset();
    check_model("mid rst");
    for (int i = 0; i < 6; i++) step(1'b1, 32'h6000 + i, 1'b0, 1'b0, "wm push");
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "wm pop");

    // Randomized traffic: a fill-biased phase, then a drain-biased phase.
    do_reset();
    model_reset();
    for (int i = 0; i < 800; i++) begin
      int wp, rp;
      wp = (i < 400) ? 70 : 40;
      rp = (i < 400) ? 40 : 70;
      step(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0, $urandom,
           ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 6)  ? 1'b1 : 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
